// File: rtl/byte_serial_subtractor_32.sv
// Multi-cycle subtractor: diff = a - b - bin, one SLICE-bit slice per clock, LSB first.
// The slice carry is held in a register between cycles; results and flags commit together.
//
// state  | meaning
// S_IDLE | waiting for start
// S_RUN  | processing slice idx each edge (busy=1)
// S_DONE | result committed, done pulse; a new start is accepted here
module byte_serial_subtractor_32 #(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             zero,
   output logic             neg,
   output logic             ovf,
   output logic             busy,
   output logic             done
);

   localparam int N     = WIDTH / SLICE;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic             carry;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] work;

   logic [SLICE-1:0] a_s;
   logic [SLICE-1:0] b_s;
   logic [SLICE:0]   slice_sum;
   logic [WIDTH-1:0] work_next;

   // Subtraction as a + ~b + carry; carry is the inverted borrow.
   always_comb begin
      a_s       = a_q[idx*SLICE +: SLICE];
      b_s       = b_q[idx*SLICE +: SLICE];
      slice_sum = {1'b0, a_s} + {1'b0, ~b_s} + {{SLICE{1'b0}}, carry};
      work_next = work;
      work_next[idx*SLICE +: SLICE] = slice_sum[SLICE-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         idx   <= '0;
         carry <= 1'b0;
         a_q   <= '0;
         b_q   <= '0;
         work  <= '0;
         diff  <= '0;
         bout  <= 1'b0;
         zero  <= 1'b0;
         neg   <= 1'b0;
         ovf   <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  a_q   <= a;
                  b_q   <= b;
                  carry <= ~bin;
                  idx   <= '0;
                  busy  <= 1'b1;
                  state <= S_RUN;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_RUN: begin
               work  <= work_next;
               carry <= slice_sum[SLICE];
               idx   <= idx + 1'b1;
               if (idx == LAST) begin
                  diff  <= work_next;
                  bout  <= ~slice_sum[SLICE];
                  zero  <= (work_next == '0);
                  neg   <= work_next[WIDTH-1];
                  ovf   <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                           (work_next[WIDTH-1] != a_q[WIDTH-1]);
                  idx   <= '0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_byte_serial_subtractor_32.sv
// Bench for byte_serial_subtractor_32: transaction-level model checked every cycle,
// plus directed vectors with literal expected results.
module tb_byte_serial_subtractor_32;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        bin = 1'b0;
   logic [31:0] diff;
   logic        bout, zero, neg, ovf, busy, done;

   int total = 0;
   int bad   = 0;

   byte_serial_subtractor_32 dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
      .diff(diff), .bout(bout), .zero(zero), .neg(neg), .ovf(ovf),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Model: an accepted operation finishes N edges later; result from 33-bit arithmetic.
   logic [31:0] m_diff, p_diff;
   logic        m_bout, m_zero, m_neg, m_ovf, m_busy, m_done;
   logic        p_bout, p_ovf;
   int          m_cnt;

   always @(posedge clk or posedge rst) begin
      logic [32:0] full;
      if (rst) begin
         m_diff = '0; m_bout = 0; m_zero = 0; m_neg = 0; m_ovf = 0;
         m_busy = 0; m_done = 0; m_cnt = 0;
         p_diff = '0; p_bout = 0; p_ovf = 0;
      end else if (m_busy) begin
         m_cnt = m_cnt - 1;
         if (m_cnt == 0) begin
            m_diff = p_diff; m_bout = p_bout; m_ovf = p_ovf;
            m_zero = (p_diff == 32'd0);
            m_neg  = p_diff[31];
            m_busy = 0; m_done = 1;
         end
      end else if (start) begin
         full   = {1'b0, a} - {1'b0, b} - {32'd0, bin};
         p_diff = full[31:0];
         p_bout = full[32];
         p_ovf  = (a[31] != b[31]) && (full[31] != a[31]);
         m_busy = 1; m_cnt = N; m_done = 0;
      end else begin
         m_done = 0;
      end
   end

   always @(negedge clk) begin
      total++;
      if (diff !== m_diff) begin
         bad++;
         $display("FAIL cyc_diff t=%0t got=%h want=%h", $time, diff, m_diff);
      end
      total++;
      if ({bout, zero, neg, ovf, busy, done} !==
          {m_bout, m_zero, m_neg, m_ovf, m_busy, m_done}) begin
         bad++;
         $display("FAIL cyc_flags t=%0t got(bout,zero,neg,ovf,busy,done)=%b want=%b", $time,
                  {bout, zero, neg, ovf, busy, done},
                  {m_bout, m_zero, m_neg, m_ovf, m_busy, m_done});
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   // Waits (bounded) for done; returns negedges counted from the first one after acceptance.
   task automatic wait_done(output int n, output int busy_cnt);
      n = 0; busy_cnt = 0;
      forever begin
         if (busy) busy_cnt++;
         n++;
         if (done) break;
         if (n >= 20) begin
            chk("done_timeout", 32'(n), 32'd5);
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic run_op(input string name, input logic [31:0] va, input logic [31:0] vb,
                         input logic vbin, input logic [31:0] ed,
                         input logic [3:0] ef /* bout,zero,neg,ovf */);
      int n, bc;
      @(negedge clk);
      a = va; b = vb; bin = vbin; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(n, bc);
      chk({name, "_lat"}, 32'(n), 32'd5);
      chk({name, "_busy"}, 32'(bc), 32'd4);
      chk({name, "_diff"}, diff, ed);
      chk({name, "_flags"}, {28'd0, bout, zero, neg, ovf}, {28'd0, ef});
      chk({name, "_model"}, {m_diff[31:0]}, ed);
   endtask

   initial begin
      int n, bc;
      repeat (2) @(negedge clk);
      chk("rst_diff", diff, 32'd0);
      chk("rst_flags", {25'd0, bout, zero, neg, ovf, busy, done, 1'b0}, 32'd0);
      rst = 1'b0;

      run_op("basic",   32'h00000005, 32'h00000003, 1'b0, 32'h00000002, 4'b0000);
      run_op("chain0",  32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 4'b1010);
      run_op("chain1",  32'h01000000, 32'h00000001, 1'b0, 32'h00FFFFFF, 4'b0000);
      run_op("ovf_pos", 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 4'b0001);
      run_op("ovf_neg", 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 4'b1011);
      run_op("zero",    32'h12345678, 32'h12345678, 1'b0, 32'h00000000, 4'b0100);
      run_op("bin1",    32'h12345678, 32'h12345678, 1'b1, 32'hFFFFFFFF, 4'b1010);

      // start and operand changes during RUN are ignored
      @(negedge clk);
      a = 32'h5; b = 32'h3; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      a = 32'hDEADBEEF; b = 32'h0BADF00D; bin = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(n, bc);
      chk("run_ign_diff", diff, 32'h00000002);
      repeat (3) @(negedge clk);
      chk("run_ign_idle", {31'd0, busy}, 32'd0);

      // start held through DONE: second op accepted, done 5 cycles after the first
      @(negedge clk);
      a = 32'h5; b = 32'h3; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      wait_done(n, bc);
      chk("b2b_first", diff, 32'h00000002);
      a = 32'h10; b = 32'h20;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      while (!done && n < 20) begin
         chk("b2b_hold", diff, 32'h00000002);
         @(negedge clk);
         n++;
      end
      chk("b2b_gap", 32'(n), 32'd5);
      chk("b2b_second", diff, 32'hFFFFFFF0);
      chk("b2b_flags", {28'd0, bout, zero, neg, ovf}, 32'b1010);

      // asynchronous reset mid-RUN
      @(negedge clk);
      a = 32'h7; b = 32'h1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_diff", diff, 32'd0);
      chk("arst_flags", {26'd0, bout, zero, neg, ovf, busy, done}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      chk("arst_nodone", {31'd0, done}, 32'd0);
      rst = 1'b0;
      run_op("post_rst", 32'h00000010, 32'h00000001, 1'b0, 32'h0000000F, 4'b0000);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
